// File: rtl/spi_apb_slave_if.sv
// APB-side bus bundle for spi_apb_slave (select/enable/direction, address, data, response).
interface spi_apb_slave_if;
  logic       PSEL;
  logic       PENABLE;
  logic       PWRITE;
  logic [2:0] PADDR;
  logic [7:0] PWDATA;
  logic [7:0] PRDATA;
  logic       PREADY;
  logic       PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/spi_apb_slave.sv
// APB register front-end for an SPI core: CR1/CR2/BR/SR/DR, tx handshake, rx capture, irq.
// Define SPI_APB_WAIT_EN to insert one WAIT state between SETUP and ENABLE.
module spi_apb_slave (
  input  logic           PCLK,
  input  logic           PRESETn,
  spi_apb_slave_if.slave apb,
  output logic [7:0]     tx_data,
  output logic           tx_valid,
  input  logic           tx_ready,
  input  logic [7:0]     rx_data,
  input  logic           rx_valid,
  output logic [7:0]     cr1,
  output logic [7:0]     cr2,
  output logic [7:0]     br,
  output logic           spi_irq
);
  localparam int unsigned DW = 8;
  localparam int unsigned AW = 3;
  localparam logic [AW-1:0] A_CR1 = AW'(0);
  localparam logic [AW-1:0] A_CR2 = AW'(1);
  localparam logic [AW-1:0] A_BR  = AW'(2);
  localparam logic [AW-1:0] A_SR  = AW'(3);
  localparam logic [AW-1:0] A_DR  = AW'(5);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_WAIT, S_ENABLE} state_t;

  state_t        r_state;
  state_t        w_state_nxt;

  logic [DW-1:0] r_cr1, r_cr2, r_br, r_rxbuf, r_tx_data, r_prdata;
  logic          r_tx_valid, r_spif, r_pready, r_pslverr;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic          r_write;

  logic          w_sptef, w_enter_en, w_err, w_commit, w_dr_read, w_spe_off;
  logic [DW-1:0] w_rdata, w_sr;

  // Transmit buffer is empty exactly when no byte is pending towards the shifter
  assign w_sptef = ~r_tx_valid;
  assign w_sr    = {r_spif, 1'b0, w_sptef, 1'b0, 4'h0};

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (apb.PSEL && !apb.PENABLE) w_state_nxt = S_SETUP;
      S_SETUP: begin
`ifdef SPI_APB_WAIT_EN
        w_state_nxt = S_WAIT;
`else
        w_state_nxt = S_ENABLE;
`endif
      end
      S_WAIT:   w_state_nxt = S_ENABLE;
      S_ENABLE: w_state_nxt = (apb.PSEL && !apb.PENABLE) ? S_SETUP : S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Address decode and error classification for the access about to enter ENABLE
  always_comb begin
    w_rdata = '0;
    w_err   = 1'b0;
    case (apb.PADDR)
      A_CR1:   w_rdata = r_cr1;
      A_CR2:   w_rdata = r_cr2;
      A_BR:    w_rdata = r_br;
      A_SR: begin
        w_rdata = w_sr;
        w_err   = apb.PWRITE;
      end
      A_DR: begin
        w_rdata = r_rxbuf;
        w_err   = apb.PWRITE & ~w_sptef;
      end
      default: w_err = 1'b1;
    endcase
  end

  assign w_enter_en = (w_state_nxt == S_ENABLE);

  // Response and access attributes are captured on entry to ENABLE so the bus may
  // move on to the next setup during ENABLE (back-to-back transfers).
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
      r_prdata  <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_write   <= 1'b0;
    end else begin
      r_pready  <= w_enter_en;
      r_pslverr <= w_enter_en & w_err;
      r_prdata  <= (w_enter_en && !apb.PWRITE && !w_err) ? w_rdata : '0;
      if (w_enter_en) begin
        r_addr  <= apb.PADDR;
        r_wdata <= apb.PWDATA;
        r_write <= apb.PWRITE;
      end
    end
  end

  assign w_commit  = (r_state == S_ENABLE) & r_write & ~r_pslverr;
  assign w_dr_read = (r_state == S_ENABLE) & ~r_write & (r_addr == A_DR);
  assign w_spe_off = w_commit & (r_addr == A_CR1) & ~r_wdata[6];

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_cr1      <= DW'(8'h04);
      r_cr2      <= '0;
      r_br       <= '0;
      r_rxbuf    <= '0;
      r_spif     <= 1'b0;
      r_tx_data  <= '0;
      r_tx_valid <= 1'b0;
    end else begin
      if (w_commit && r_addr == A_CR1) r_cr1 <= r_wdata;
      if (w_commit && r_addr == A_CR2) r_cr2 <= r_wdata;
      if (w_commit && r_addr == A_BR)  r_br  <= r_wdata;
      // A fresh receive strobe beats the read-clear of SPIF
      if (rx_valid) begin
        r_rxbuf <= rx_data;
        r_spif  <= 1'b1;
      end else if (w_dr_read) begin
        r_spif  <= 1'b0;
      end
      if (w_commit && r_addr == A_DR) begin
        r_tx_data  <= r_wdata;
        r_tx_valid <= 1'b1;
      end else if (w_spe_off || (r_tx_valid && tx_ready)) begin
        r_tx_valid <= 1'b0;
      end
    end
  end

  assign apb.PRDATA  = r_prdata;
  assign apb.PREADY  = r_pready;
  assign apb.PSLVERR = r_pslverr;
  assign tx_data     = r_tx_data;
  assign tx_valid    = r_tx_valid;
  assign cr1         = r_cr1;
  assign cr2         = r_cr2;
  assign br          = r_br;
  assign spi_irq     = (r_cr1[7] & r_spif) | (r_cr1[5] & w_sptef);
endmodule

// File: doc/spi_apb_slave.md
SPI_APB_SLAVE -- requirements
Module: spi_apb_slave

Interface
REQ-001 SHALL provide PCLK, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL provide PRESETn, input, 1, reset; asynchronous, active-low.
REQ-003 SHALL provide PSEL, PENABLE, PWRITE, inputs, 1 each, APB select/enable/direction.
REQ-004 SHALL provide PADDR, input, 3, register address; PWDATA, input, 8, write data.
REQ-005 SHALL provide PRDATA, output, 8, read data; PREADY, output, 1, transfer complete; PSLVERR, output, 1, transfer error.
REQ-006 SHALL provide tx_data, output, 8, byte to shifter; tx_valid, output, 1; tx_ready, input, 1, shifter accepts byte.
REQ-007 SHALL provide rx_data, input, 8, received byte; rx_valid, input, 1, single-cycle receive strobe.
REQ-008 SHALL provide cr1, cr2, br, outputs, 8 each, register contents to SPI core; spi_irq, output, 1, interrupt.

Function
REQ-009 SHALL decode PADDR: 0 CR1 (RW), 1 CR2 (RW), 2 BR (RW), 3 SR (RO), 5 DR (RW); 4, 6, 7 reserved.
REQ-010 SHALL implement FSM IDLE, SETUP, ENABLE (plus WAIT per REQ-026); reset state IDLE.
REQ-011 SHALL transition IDLE->SETUP when PSEL=1 and PENABLE=0; otherwise remain IDLE.
REQ-012 SHALL transition SETUP->ENABLE unconditionally (SETUP->WAIT when REQ-026 is enabled).
REQ-013 SHALL transition ENABLE->SETUP when PSEL=1 and PENABLE=0 (back-to-back), otherwise ENABLE->IDLE.
REQ-014 SHALL drive PREADY=1 only in ENABLE; 0 in IDLE, SETUP, WAIT.
REQ-015 SHALL commit writes on the ENABLE cycle only; read data SHALL be valid on PRDATA during ENABLE and be 0x00 in all other states.
REQ-016 SHALL assert PSLVERR during ENABLE for: reserved address, write to SR, write to DR while SR.SPTEF=0; such writes SHALL not alter any state; PSLVERR=0 in all other cycles.
REQ-017 SHALL compose SR as: bit7 SPIF, bit5 SPTEF, bit4 MODF (always 0), other bits 0.
REQ-018 SHALL, on a valid DR write, load tx_data, set tx_valid=1, clear SPTEF on the same edge.
REQ-019 SHALL hold tx_valid and tx_data stable until tx_ready=1 is sampled with tx_valid=1; on that edge tx_valid->0, SPTEF->1.
REQ-020 SHALL, on rx_valid=1, capture rx_data into the receive buffer and set SPIF; a second rx_valid before read overwrites the buffer.
REQ-021 SHALL clear SPIF on the ENABLE cycle of a DR read; if rx_valid coincides, set wins (SPIF stays 1, buffer gets new byte).
REQ-022 SHALL, when cr1[6] (SPE) is written 0, drop tx_valid and set SPTEF on the same edge; SPIF unaffected.
REQ-023 SHALL drive spi_irq = (cr1[7] & SPIF) | (cr1[5] & SPTEF), combinational from registers.

Reset
REQ-024 SHALL, while PRESETn=0, force: FSM IDLE, cr1=0x04, cr2=0x00, br=0x00, SPIF=0, SPTEF=1, receive buffer 0x00, tx_data=0x00, tx_valid=0, PRDATA=0x00, PREADY=0, PSLVERR=0, spi_irq=0.
REQ-025 SHALL, on reset asserted mid-transfer, abandon the transfer with no register update; first transfer after release SHALL start from IDLE.

Configuration
REQ-026 SHALL, with macro SPI_APB_WAIT_EN defined, insert exactly one WAIT state between SETUP and ENABLE (PREADY=0 there, write commit deferred to ENABLE); without the macro, zero-wait transfers (SETUP->ENABLE, PREADY high in second transfer cycle).

Verification
REQ-027 Reset then read addr 0,1,2,3 -> PRDATA 0x04, 0x00, 0x00, 0x20; PSLVERR=0 each.
REQ-028 Write CR1=0xE0, read back -> 0xE0, spi_irq=1 (SPTIE with SPTEF=1); write addr 6 -> PSLVERR=1, no register change.
REQ-029 Write DR=0xA5 with tx_ready=0 for 5 cycles -> tx_valid=1, tx_data=0xA5 stable, SR=0x00; second DR write -> PSLVERR=1; tx_ready=1 -> tx_valid=0, SR=0x20.
REQ-030 Pulse rx_valid with rx_data=0x3C -> SR=0xA0; read DR -> 0x3C, then SR=0x20; repeat with rx_valid on DR-read ENABLE cycle -> SPIF remains 1.
REQ-031 Back-to-back write CR2=0x11 then read CR2 with PSEL held -> ENABLE->SETUP transition, read returns 0x11; with SPI_APB_WAIT_EN, each transfer takes 3 cycles, PREADY low in WAIT.
REQ-032 Assert PRESETn=0 during SETUP of a CR1=0xFF write -> CR1 remains 0x04 after release.
